sram_result_reader: RTL and testbench
=====================================

# sram_result_reader

Read-out stage downstream of the SRAM result memory. After the datapath reports compute completion, it walks the result SRAM from address 0 using the `read_n`/`ry` read handshake. Each captured 9-bit word goes into a small FIFO, which is drained through a valid/ready stream to the chip output. It owns `read_n` and `r_addr` of the SRAM; the SRAM's `read_data` and `ry` are its inputs.

## Interface
Parameters:
- `NUM_WORDS`, 16: words read per run.
- `ADDR_W`, 4: width of `r_addr`; `NUM_WORDS` ≤ 2^`ADDR_W`.
- `FIFO_DEPTH`, 4: output FIFO entries; power of two, ≥ 2.
- `RY_TIMEOUT`, 255: maximum cycles to wait for `ry` per request; ≥ 1, ≤ 255.

Ports:
- `clk`, input, 1: single clock; all logic on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: one-cycle pulse that begins a run; normally wired to `ALU_done`.
- `read_n`, output, 1: active-low SRAM read request.
- `r_addr`, output, `ADDR_W`: SRAM read address.
- `ry`, input, 1: SRAM ready; `read_data` is valid in any cycle where `ry`=1 and `read_n`=0.
- `read_data`, input, 9: SRAM read data.
- `out_data`, output, 9: FIFO head word.
- `out_valid`, output, 1: FIFO not empty.
- `out_ready`, input, 1: consumer accepts `out_data` this cycle.
- `busy`, output, 1: a run is in progress.
- `done`, output, 1: one-cycle pulse at the end of a run.
- `error`, output, 1: `ry` timeout occurred in the current or last run.
- `checksum`, output, 16: present only with `RESULT_CHECKSUM_EN`.

## Operation
- States: IDLE, REQ, WAIT_RY, GAP, DRAIN, FIN.
- IDLE
  - `start`=1 → REQ; clears `error`, the word counter, and the checksum.
  - `start` in any other state is ignored.
- REQ
  - Entered only when FIFO occupancy < `FIFO_DEPTH`; otherwise the FSM waits in REQ with `read_n`=1.
  - When space exists: drive `read_n`=0 with `r_addr` = word counter → WAIT_RY.
- WAIT_RY
  - `read_n` is held 0 and `r_addr` is held stable.
  - `ry`=1: push `read_data` into the FIFO; increment the word counter; `read_n`=1 next cycle → GAP.
  - Timeout counter reaches `RY_TIMEOUT` with no `ry`: set `error`; `read_n`=1; no push; remaining words skipped → DRAIN.
- GAP
  - One cycle with `read_n`=1, so requests never run back-to-back.
  - If word counter = `NUM_WORDS` → DRAIN, else → REQ.
- DRAIN
  - Wait until the FIFO is empty → FIN.
- FIN
  - `done`=1 for one cycle → IDLE.
- FIFO
  - Circular buffer; read and write pointers wrap modulo `FIFO_DEPTH`.
  - Pop condition: `out_valid` & `out_ready`.
  - Push and pop in the same cycle leave occupancy unchanged; this is legal even when full.
  - Pop when empty is ignored.
  - A push never occurs when full, because REQ reserves the space.
- `busy` = 1 in every state except IDLE.
- Reset mid-run: the FSM returns to IDLE, the FIFO is flushed, `read_n`=1, and no `done` pulse is produced.

## Timing
- Reset values:
  - `read_n`=1, `r_addr`=0.
  - `out_valid`=0, `out_data`=0.
  - `busy`=0, `done`=0, `error`=0, `checksum`=0.
- `start` at cycle t → `read_n`=0 and `busy`=1 at t+1.
- `ry` seen at cycle c:
  - The word appears on `out_data` with `out_valid`=1 at c+1 if the FIFO was empty.
  - `read_n`=1 at c+1.
  - The next request asserts at c+3 at the earliest.
- Peak throughput is 1 word per 3 cycles when `ry` returns in the same cycle as the request.
- `out_data` is stable while `out_valid`=1 and `out_ready`=0.
- `done` is asserted in the cycle after the FIFO becomes empty with all words captured; `busy` falls together with `done`.
- Timeout: with `read_n` falling at cycle t, `error` rises at t+`RY_TIMEOUT`. `error` stays sticky until the next accepted `start`.

## Configuration
- `RESULT_CHECKSUM_EN` defined:
  - 16-bit running sum, modulo 2^16, of the zero-extended `read_data` of every captured word.
  - Updated on each push.
  - `checksum` is valid and stable from `done` until the next `start`.
- Undefined: no `checksum` port and no accumulator logic.

## Test plan
- Nominal run: `NUM_WORDS`=16; `ry` returns 2 cycles after each request; `read_data`=addr+5; `out_ready`=1 → `out_data` sequence 5..20; `done` once; `error`=0; checksum 200 (0x00C8).
- Backpressure: `out_ready`=0 until 4 words are captured → requests stop with `read_n`=1. Releasing `out_ready` resumes at address 4; no word is lost or duplicated.
- Simultaneous push/pop with the FIFO full, `out_ready` toggling every cycle → occupancy never exceeds 4 and order is preserved.
- Timeout: `ry` held 0 at address 3, `RY_TIMEOUT`=10 → `error` rises 10 cycles after `read_n` falls. Words 0–2 are delivered, then `done`.
- `rst` asserted in WAIT_RY → next cycle `read_n`=1, `out_valid`=0, `busy`=0, and no `done` pulse. A subsequent `start` reads from address 0.
- `start` pulsed during a run → ignored; exactly one `done` pulse and 16 output words.

Source files
------------

// File: rtl/sram_result_reader.sv
// -----------------------------------------------------------------------------
// sram_result_reader
//
// Read-out stage behind the result SRAM. A start pulse (normally ALU_done)
// launches a run that reads NUM_WORDS words from address 0 upwards using the
// SRAM's read_n/ry handshake. Each captured 9-bit word is pushed into a small
// circular FIFO, and the FIFO is drained to the chip output through a
// valid/ready stream.
//
// Optional feature (compile-time macro): RESULT_CHECKSUM_EN
//   When defined, a 16-bit running sum (mod 2^16) of every captured word is
//   kept and presented on `checksum`. When undefined, the port and the
//   accumulator are absent.
//
// Ports:
//   clk         in   single clock, rising edge
//   rst         in   synchronous, active-high reset
//   start       in   one-cycle pulse that begins a run (ignored unless idle)
//   read_n      out  active-low SRAM read request
//   r_addr      out  SRAM read address [ADDR_W]
//   ry          in   SRAM ready; read_data valid when ry=1 and read_n=0
//   read_data   in   SRAM read data [9]
//   out_data    out  FIFO head word [9] (0 when the FIFO is empty)
//   out_valid   out  FIFO not empty
//   out_ready   in   consumer accepts out_data this cycle
//   busy        out  a run is in progress (any state but IDLE)
//   done        out  one-cycle pulse at the end of a run
//   error       out  ry timeout in the current or last run (sticky)
//   checksum    out  running sum [16] (RESULT_CHECKSUM_EN only)
//   dbg_state_o out  current FSM state, for checkers and debug
//                    (IDLE=0 REQ=1 WAIT_RY=2 GAP=3 DRAIN=4 FIN=5)
//
// Output stream handshake: a word transfers in every cycle where
// out_valid=1 and out_ready=1. out_valid never depends on out_ready, and
// out_data holds steady while out_valid=1 and out_ready=0.
// -----------------------------------------------------------------------------
module sram_result_reader #(
    parameter int NUM_WORDS  = 16,
    parameter int ADDR_W     = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int RY_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              read_n,
    output logic [ADDR_W-1:0] r_addr,
    input  logic              ry,
    input  logic [8:0]        read_data,
    output logic [8:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              error,
`ifdef RESULT_CHECKSUM_EN
    output logic [15:0]       checksum,
`endif
    output logic [2:0]        dbg_state_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    // One extra bit so the counter can hold NUM_WORDS itself (<= 2^ADDR_W).
    localparam int CNT_W = ADDR_W + 1;

    localparam logic [PTR_W:0]   OCC_FULL = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS);
    // The timeout counter starts at 0 in the first WAIT_RY cycle, so the
    // last cycle we may still wait is RY_TIMEOUT-1.
    localparam logic [7:0]       TO_LAST  = 8'(RY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_WAIT_RY = 3'd2,
        S_GAP     = 3'd3,
        S_DRAIN   = 3'd4,
        S_FIN     = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic              read_n_q, read_n_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic [7:0]        to_cnt_q, to_cnt_d;
    logic              error_q, error_d;

    logic              push;
    logic              pop;
    logic              fifo_space;

    logic [8:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    occ_q, occ_d;

    // -------------------------------------------------------------------------
    // Control FSM: next state and next register values
    // -------------------------------------------------------------------------
    assign fifo_space = (occ_q < OCC_FULL);

    always_comb begin
        state_d    = state_q;
        read_n_d   = read_n_q;
        word_cnt_d = word_cnt_q;
        to_cnt_d   = to_cnt_q;
        error_d    = error_q;
        push       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    error_d    = 1'b0;
                    word_cnt_d = '0;
                    to_cnt_d   = '0;
                    // The FIFO is always empty in IDLE (a run only ends after
                    // DRAIN, and reset flushes it), so the space check REQ
                    // would make already holds: issue the first request now
                    // so read_n falls the cycle after start.
                    read_n_d   = 1'b0;
                    state_d    = S_WAIT_RY;
                end
            end

            S_REQ: begin
                // Only request when the word has somewhere to go; the single
                // outstanding request is what reserves the FIFO slot.
                if (fifo_space) begin
                    read_n_d = 1'b0;
                    to_cnt_d = '0;
                    state_d  = S_WAIT_RY;
                end
            end

            S_WAIT_RY: begin
                if (ry) begin
                    push       = 1'b1;
                    word_cnt_d = word_cnt_q + 1'b1;
                    read_n_d   = 1'b1;
                    state_d    = S_GAP;
                end else if (to_cnt_q == TO_LAST) begin
                    // Give up on this and all remaining words.
                    error_d  = 1'b1;
                    read_n_d = 1'b1;
                    state_d  = S_DRAIN;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end

            S_GAP: begin
                // One idle cycle between requests keeps them from running
                // back-to-back on the SRAM.
                if (word_cnt_q == LAST_CNT) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_REQ;
                end
            end

            S_DRAIN: begin
                if (occ_q == '0) begin
                    state_d = S_FIN;
                end
            end

            S_FIN: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d  = S_IDLE;
                read_n_d = 1'b1;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output FIFO: pointers wrap naturally since FIFO_DEPTH is a power of two
    // -------------------------------------------------------------------------
    assign out_valid = (occ_q != '0);
    assign pop       = out_valid & out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    // Storage is not reset; out_data is gated so an empty FIFO shows 0.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= read_data;
        end
    end

    assign out_data = out_valid ? fifo_mem[rd_ptr_q] : 9'd0;

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            read_n_q   <= 1'b1;
            word_cnt_q <= '0;
            to_cnt_q   <= '0;
            error_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
        end else begin
            state_q    <= state_d;
            read_n_q   <= read_n_d;
            word_cnt_q <= word_cnt_d;
            to_cnt_q   <= to_cnt_d;
            error_q    <= error_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
        end
    end

`ifdef RESULT_CHECKSUM_EN
    // -------------------------------------------------------------------------
    // Running checksum of captured words; holds its value from done until the
    // next accepted start.
    // -------------------------------------------------------------------------
    logic [15:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (state_q == S_IDLE && start) begin
            checksum_d = '0;
        end else if (push) begin
            checksum_d = checksum_q + {7'd0, read_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign read_n      = read_n_q;
    // Bits above ADDR_W only matter once the run has reached NUM_WORDS.
    assign r_addr      = word_cnt_q[ADDR_W-1:0];
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_FIN);
    assign error       = error_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sram_result_reader.sv
module tb_sram_result_reader;

  localparam int NUM_WORDS  = 16;
  localparam int ADDR_W     = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int RY_TIMEOUT = 10;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              read_n;
  logic [ADDR_W-1:0] r_addr;
  logic              ry;
  logic [8:0]        read_data;
  logic [8:0]        out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;
  logic              error;
  logic [2:0]        dbg_state;
`ifdef RESULT_CHECKSUM_EN
  logic [15:0]       checksum;
`endif

  always #5 clk = ~clk;

  sram_result_reader #(
    .NUM_WORDS (NUM_WORDS),
    .ADDR_W    (ADDR_W),
    .FIFO_DEPTH(FIFO_DEPTH),
    .RY_TIMEOUT(RY_TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .read_n     (read_n),
    .r_addr     (r_addr),
    .ry         (ry),
    .read_data  (read_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .error      (error),
`ifdef RESULT_CHECKSUM_EN
    .checksum   (checksum),
`endif
    .dbg_state_o(dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard and reference model state
  // ---------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;

  logic [8:0] sram_mem [NUM_WORDS];
  logic [8:0] exp_q [$];

  int   cyc          = 0;
  int   model_addr   = 0;   // next word index the run should request
  int   last_cap     = -100;
  int   fall_cyc     = 0;
  int   lat_left     = 0;
  int   lat_min      = 0;
  int   lat_max      = 0;
  int   timeout_addr = -1;  // word whose ry never comes (-1: none)
  int   ready_pct    = 100;
  int   prev_occ     = 0;
  int   done_cnt     = 0;
  int   words_out    = 0;
  bit   timed_out    = 0;
  bit   hold_ready   = 0;
  bit   toggle_ready = 0;
  bit   start_now    = 0;
  bit   rst_now      = 0;
  logic prev_read_n  = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // One clock cycle: observe at the falling edge, check against the model,
  // then drive this cycle's inputs (SRAM responder, consumer, start, rst).
  // ---------------------------------------------------------------------------
  task automatic tick();
    bit cap;
    bit pop;
    @(negedge clk);
    cyc++;

    check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) check("out_data", 32'(out_data), 32'(exp_q[0]));
    if (cyc == last_cap + 1) check("read_n_release", 32'(read_n), 32'd1);

    if (!read_n) begin
      check("r_addr", 32'(r_addr), 32'(model_addr % (1 << ADDR_W)));
      if (prev_read_n) begin
        check("req_space", 32'(prev_occ < FIFO_DEPTH), 32'd1);
        check("req_gap", 32'(cyc - last_cap >= 3), 32'd1);
        check("req_after_timeout", 32'(timed_out), 32'd0);
        fall_cyc = cyc;
        lat_left = int'($urandom_range(lat_max, lat_min));
      end
    end

    if (timeout_addr >= 0 && model_addr == timeout_addr && fall_cyc > 0) begin
      if (cyc == fall_cyc + RY_TIMEOUT - 1) check("error_early", 32'(error), 32'd0);
      if (cyc == fall_cyc + RY_TIMEOUT) begin
        check("error_rise", 32'(error), 32'd1);
        check("timeout_read_n", 32'(read_n), 32'd1);
        timed_out = 1;
      end
    end

    if (done) begin
      done_cnt++;
      check("busy_at_done", 32'(busy), 32'd1);
      check("drained_at_done", 32'(exp_q.size()), 32'd0);
    end

    // drive inputs for this cycle
    start     = start_now;
    start_now = 0;
    ry        = 1'b0;
    read_data = 9'($urandom);
    if (read_n) begin
      ry = 1'($urandom_range(1, 0));   // must be ignored without a request
    end else if (model_addr != timeout_addr) begin
      if (lat_left == 0) begin
        ry        = 1'b1;
        read_data = (model_addr < NUM_WORDS) ? sram_mem[model_addr] : 9'h1ff;
      end else begin
        lat_left--;
      end
    end

    if (hold_ready)        out_ready = 1'b0;
    else if (toggle_ready) out_ready = ~out_ready;
    else                   out_ready = (int'($urandom_range(99, 0)) < ready_pct);

    rst = rst_now;
    if (rst_now) begin
      rst_now  = 0;
      exp_q.delete();
      prev_occ = 0;
    end else begin
      cap = !read_n && ry;
      pop = out_valid && out_ready;
      if (cap) check("push_not_full", 32'(exp_q.size() < FIFO_DEPTH), 32'd1);
      prev_occ = exp_q.size();
      if (pop && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        words_out++;
      end
      if (cap) begin
        exp_q.push_back(read_data);
        model_addr++;
        last_cap = cyc;
      end
    end
    prev_read_n = read_n;
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic fill_random();
    for (int i = 0; i < NUM_WORDS; i++) sram_mem[i] = 9'($urandom);
  endtask

  task automatic begin_run(input int to_addr, input int lmin, input int lmax, input int rpct);
    timeout_addr = to_addr;
    lat_min      = lmin;
    lat_max      = lmax;
    ready_pct    = rpct;
    model_addr   = 0;
    timed_out    = 0;
    last_cap     = -100;
    fall_cyc     = 0;
    done_cnt     = 0;
    words_out    = 0;
    start_now    = 1;
    tick();
    tick();
    check("start_read_n", 32'(read_n), 32'd0);
    check("start_busy", 32'(busy), 32'd1);
  endtask

  task automatic run_one(input string name, input int to_addr, input int lmin, input int lmax,
                         input int rpct, input bit tgl, input int bp_release, input bit mid_start);
    int          n;
    int          exp_words;
    logic [15:0] exp_sum;
    exp_words = (to_addr >= 0) ? to_addr : NUM_WORDS;
    exp_sum   = '0;
    for (int i = 0; i < exp_words; i++) exp_sum += 16'(sram_mem[i]);
    hold_ready   = (bp_release > 0);
    toggle_ready = tgl && (bp_release == 0);
    begin_run(to_addr, lmin, lmax, rpct);
    n = 0;
    while (done_cnt == 0 && n < 3000) begin
      if (mid_start && n == 25) start_now = 1;
      if (bp_release > 0 && n == bp_release - 1) begin
        check({name, "/stall_addr"}, 32'(model_addr), 32'(FIFO_DEPTH));
        check({name, "/stall_read_n"}, 32'(read_n), 32'd1);
      end
      if (bp_release > 0 && n == bp_release) begin
        hold_ready   = 0;
        toggle_ready = tgl;
      end
      tick();
      n++;
    end
    check({name, "/done_seen"}, 32'(done_cnt), 32'd1);
    check({name, "/words"}, 32'(words_out), 32'(exp_words));
    check({name, "/error"}, 32'(error), 32'(to_addr >= 0));
`ifdef RESULT_CHECKSUM_EN
    check({name, "/checksum"}, 32'(checksum), 32'(exp_sum));
`endif
    toggle_ready = 0;
    repeat (4) tick();
    check({name, "/busy_after"}, 32'(busy), 32'd0);
    check({name, "/done_once"}, 32'(done_cnt), 32'd1);
    check({name, "/idle_read_n"}, 32'(read_n), 32'd1);
    check({name, "/error_sticky"}, 32'(error), 32'(to_addr >= 0));
`ifdef RESULT_CHECKSUM_EN
    check({name, "/checksum_hold"}, 32'(checksum), 32'(exp_sum));
`endif
  endtask

  task automatic reset_mid_run();
    int n;
    fill_random();
    hold_ready   = 0;
    toggle_ready = 0;
    begin_run(5, 0, 1, 100);
    n = 0;
    while (!(model_addr == 5 && !read_n && cyc >= fall_cyc + 3) && n < 300) begin
      tick();
      n++;
    end
    check("rst/reached_wait", 32'(model_addr == 5 && !read_n), 32'd1);
    rst_now = 1;
    tick();
    timeout_addr = -1;
    tick();
    check("rst/read_n", 32'(read_n), 32'd1);
    check("rst/out_valid", 32'(out_valid), 32'd0);
    check("rst/busy", 32'(busy), 32'd0);
    check("rst/error", 32'(error), 32'd0);
    check("rst/r_addr", 32'(r_addr), 32'd0);
    repeat (20) tick();
    check("rst/no_done", 32'(done_cnt), 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    ry        = 1'b0;
    read_data = 9'd0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset/read_n", 32'(read_n), 32'd1);
    check("reset/r_addr", 32'(r_addr), 32'd0);
    check("reset/out_valid", 32'(out_valid), 32'd0);
    check("reset/out_data", 32'(out_data), 32'd0);
    check("reset/busy", 32'(busy), 32'd0);
    check("reset/done", 32'(done), 32'd0);
    check("reset/error", 32'(error), 32'd0);
    check("reset/state_idle", 32'(dbg_state), 32'd0);
`ifdef RESULT_CHECKSUM_EN
    check("reset/checksum", 32'(checksum), 32'd0);
`endif
    rst = 1'b0;

    for (int i = 0; i < NUM_WORDS; i++) sram_mem[i] = 9'(i + 5);
    run_one("nominal", -1, 2, 2, 100, 0, 0, 0);

    fill_random();
    run_one("backpressure", -1, 0, 2, 100, 1, 40, 0);

    fill_random();
    run_one("timeout", 3, 0, 3, 70, 0, 0, 0);

    reset_mid_run();
    fill_random();
    run_one("after_rst", -1, 0, 3, 80, 0, 0, 0);

    fill_random();
    run_one("mid_start", -1, 0, 2, 90, 0, 0, 1);

    for (int r = 0; r < 4; r++) begin
      fill_random();
      run_one("random",
              ($urandom_range(3, 0) == 0) ? int'($urandom_range(NUM_WORDS - 1, 1)) : -1,
              0, int'($urandom_range(4, 0)), int'($urandom_range(100, 20)), 0, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
